// File: rtl/gf2_poly_divider_if.sv
// Handshake bundle for the GF(2)[x] long divider.
// master: start/a/b requester; slave: divider (busy/done/dz/q/r).
interface gf2_poly_divider_if #(
  parameter int N = 233
) ();
  logic           start;
  logic [2*N-1:0] a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic           dz;
  logic [2*N-1:0] q;
  logic [N-1:0]   r;

  modport master (
    output start, a, b,
    input  busy, done, dz, q, r
  );

  modport slave (
    input  start, a, b,
    output busy, done, dz, q, r
  );
endinterface

// File: rtl/gf2_poly_divider.sv
// Bit-serial GF(2)[x] divider: a (2N) / b (N) -> q (2N), r (N).
// Ports: clk, rst (sync, high), io: start/a/b in, busy/done/dz/q/r out.
module gf2_poly_divider #(
  parameter int N = 233
) (
  input  logic               clk,
  input  logic               rst,
  gf2_poly_divider_if.slave  io
);
  localparam int W2 = 2 * N;
  localparam int IW = $clog2(W2);
  localparam int DW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    DEG,
    DIV,
    FIN
  } state_t;

  state_t          st;
  logic [W2-1:0]   w;
  logic [N-1:0]    d;
  logic [IW-1:0]   idx;
  logic [DW-1:0]   deg_b;
  logic [W2-1:0]   q_q;
  logic [N-1:0]    r_q;
  logic            busy_q;
  logic            done_q;
  logic            dz_q;

  logic [DW-1:0]   msb;
  logic [IW-1:0]   sh;
  logic            hit;
  logic [W2-1:0]   w_nxt;

  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.dz   = dz_q;
  assign io.q    = q_q;
  assign io.r    = r_q;

  // highest set bit of the divisor wins
  always_comb begin
    msb = '0;
    for (int k = 0; k < N; k++) begin
      if (d[k]) msb = k[DW-1:0];
    end
  end

  // one long-division step at bit idx
  always_comb begin
    sh    = idx - IW'(deg_b);
    hit   = (idx >= IW'(deg_b)) && w[idx];
    w_nxt = w;
    if (hit) w_nxt = w ^ ({{N{1'b0}}, d} << sh);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      w      <= '0;
      d      <= '0;
      idx    <= '0;
      deg_b  <= '0;
      q_q    <= '0;
      r_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          done_q <= 1'b0;
          if (io.start) begin
            w      <= io.a;
            d      <= io.b;
            q_q    <= '0;
            dz_q   <= 1'b0;
            busy_q <= 1'b1;
            st     <= DEG;
          end
        end
        DEG: begin
          deg_b <= msb;
          idx   <= IW'(W2 - 1);
          if (d == '0) begin
            dz_q   <= 1'b1;
            q_q    <= '0;
            r_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            st     <= FIN;
          end else begin
            st <= DIV;
          end
        end
        DIV: begin
          w <= w_nxt;
          if (hit) q_q[sh] <= 1'b1;
          if (idx == '0) begin
            r_q    <= w_nxt[N-1:0];
            busy_q <= 1'b0;
            done_q <= 1'b1;
            st     <= FIN;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        FIN: begin
          done_q <= 1'b0;
          st     <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gf2_poly_divider.sv
// Directed + invariant bench for gf2_poly_divider.
// Drives io master side; checks q/r/dz/latency/handshake.
module tb_gf2_poly_divider;
  localparam int N  = 233;
  localparam int W2 = 2 * N;
  localparam int W3 = 3 * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  gf2_poly_divider_if #(.N(N)) io ();

  gf2_poly_divider #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  task automatic chk(input string tag,
                     input logic [W3-1:0] got,
                     input logic [W3-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W3-1:0] clmul(input logic [W2-1:0] x,
                                          input logic [N-1:0] y);
    logic [W3-1:0] p;
    p = '0;
    for (int j = 0; j < N; j++) begin
      if (y[j]) p = p ^ ({{N{1'b0}}, x} << j);
    end
    return p;
  endfunction

  function automatic int deg(input logic [N-1:0] v);
    int dg;
    dg = -1;
    for (int k = 0; k < N; k++) begin
      if (v[k]) dg = k;
    end
    return dg;
  endfunction

  function automatic logic [W2-1:0] rnd(input int nbits);
    logic [W2-1:0] v;
    v = '0;
    for (int k = 0; k < nbits; k++) v[k] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic run_op(input  logic [W2-1:0] av,
                        input  logic [N-1:0]  bv,
                        input  int            p1,
                        input  int            p2,
                        output logic [W2-1:0] qo,
                        output logic [N-1:0]  ro,
                        output logic          dzo,
                        output int            lat);
    int extra;
    bit seen;
    @(negedge clk);
    io.a     = av;
    io.b     = bv;
    io.start = 1'b1;
    @(posedge clk);
    #1;
    io.start = 1'b0;
    io.a     = ~av;
    io.b     = ~bv;
    lat      = 1;
    seen     = 1'b0;
    for (int k = 0; k < 600 && !seen; k++) begin
      io.start = (k == p1 || k == p2);
      @(posedge clk);
      #1;
      lat++;
      if (io.done) seen = 1'b1;
    end
    io.start = 1'b0;
    if (!seen) chk("done_timeout", 0, 1);
    qo    = io.q;
    ro    = io.r;
    dzo   = io.dz;
    extra = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (io.done) extra++;
    end
    chk("single_done", W3'(extra), 0);
    chk("busy_after", W3'(io.busy), 0);
    chk("q_hold", W3'(io.q), W3'(qo));
  endtask

  logic [W2-1:0] q, a, x;
  logic [N-1:0]  r, b;
  logic          dz;
  int            lat;
  int            dcnt;

  initial begin
    io.start = 1'b0;
    io.a     = '0;
    io.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", W3'(io.busy), 0);
    chk("rst_done", W3'(io.done), 0);
    chk("rst_dz", W3'(io.dz), 0);
    chk("rst_q", W3'(io.q), 0);
    chk("rst_r", W3'(io.r), 0);

    run_op(W2'(32'h11), N'(3), -1, -1, q, r, dz, lat);
    chk("t1_lat", W3'(lat), 468);
    chk("t1_q", W3'(q), W3'(32'hF));
    chk("t1_r", W3'(r), 0);
    chk("t1_dz", W3'(dz), 0);

    run_op(W2'(32'h13), N'(7), -1, -1, q, r, dz, lat);
    chk("t2a_q", W3'(q), W3'(32'h6));
    chk("t2a_r", W3'(r), W3'(32'h1));

    a = '0;
    a[233] = 1'b1;
    b = '0;
    b[232] = 1'b1;
    b[74]  = 1'b1;
    b[0]   = 1'b1;
    run_op(a, b, -1, -1, q, r, dz, lat);
    chk("t2b_q", W3'(q), W3'(32'h2));
    chk("t2b_r", W3'(r), (W3'(1) << 75) | W3'(2));

    run_op(W2'(32'hDEAD), '0, -1, -1, q, r, dz, lat);
    chk("t3_lat", W3'(lat), 2);
    chk("t3_dz", W3'(dz), 1);
    chk("t3_q", W3'(q), 0);
    chk("t3_r", W3'(r), 0);
    run_op(W2'(32'hABC), N'(1), -1, -1, q, r, dz, lat);
    chk("t3b_dz", W3'(dz), 0);
    chk("t3b_q", W3'(q), W3'(32'hABC));
    chk("t3b_r", W3'(r), 0);
    chk("t3b_lat", W3'(lat), 468);

    run_op(W2'(32'h11), N'(3), 4, 299, q, r, dz, lat);
    chk("t5_lat", W3'(lat), 468);
    chk("t5_q", W3'(q), W3'(32'hF));
    chk("t5_r", W3'(r), 0);

    for (int t = 0; t < 8; t++) begin
      x = rnd($urandom_range(1, N));
      b = N'(rnd($urandom_range(1, N)));
      if (b == '0) b = N'(1);
      a = W2'(clmul(x, b));
      run_op(a, b, -1, -1, q, r, dz, lat);
      chk("t4_fac_q", W3'(q), W3'(x));
      chk("t4_fac_r", W3'(r), 0);
    end

    for (int t = 0; t < 12; t++) begin
      a = rnd($urandom_range(1, W2));
      b = N'(rnd($urandom_range(1, N)));
      if (b == '0) b = N'(5);
      run_op(a, b, -1, -1, q, r, dz, lat);
      chk("t4_inv", clmul(q, b) ^ W3'(r), W3'(a));
      chk("t4_deg", W3'(deg(r) < deg(b)), 1);
    end

    @(negedge clk);
    io.a     = W2'(32'h13);
    io.b     = N'(7);
    io.start = 1'b1;
    @(negedge clk);
    io.start = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t6_busy", W3'(io.busy), 0);
    chk("t6_q", W3'(io.q), 0);
    chk("t6_r", W3'(io.r), 0);
    dcnt = 0;
    repeat (480) begin
      @(posedge clk);
      #1;
      if (io.done) dcnt++;
    end
    chk("t6_no_done", W3'(dcnt), 0);
    run_op(W2'(32'h11), N'(3), -1, -1, q, r, dz, lat);
    chk("t6_lat", W3'(lat), 468);
    chk("t6_q2", W3'(q), W3'(32'hF));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
